wish_pack_flex: RTL and testbench
=================================

Name: wish_pack_flex

Overview:
- Wishbone-style width packer; successor to the fixed-ratio packer.
- Accepts narrow beats on a slave port and emits one wide word of MAX_PACK lanes on a master port.
- Pack count is selectable at runtime, per group.
- Partial groups are flushed on cycle end or tag change, with lane-valid select bits.
- A double-buffered accumulator sustains one beat per cycle under steady downstream ack.

Parameters:
- DATA_WIDTH, 8: bits per input beat / output lane.
- MAX_PACK, 4: output lanes; must be ≥2.
- TGC_WIDTH, 2: cycle-tag width carried per group.
- LITTLE_ENDIAN, 0: lane ordering; 1 = first beat in the least-significant lane.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- cfg_num_i  in  CW=$clog2(MAX_PACK)+1  beats per group; 0 or >MAX_PACK is treated as MAX_PACK.
- s_cyc_i  in  1  slave cycle valid.
- s_stb_i  in  1  slave strobe.
- s_dat_i  in  DATA_WIDTH  slave data.
- s_tgc_i  in  TGC_WIDTH  slave cycle tag.
- s_stall_o  out  1  slave stall.
- s_ack_o  out  1  slave ack; registered.
- d_cyc_o  out  1  master cycle.
- d_stb_o  out  1  master strobe.
- d_dat_o  out  DATA_WIDTH*MAX_PACK  packed word.
- d_sel_o  out  MAX_PACK  lane-valid bits.
- d_tgc_o  out  TGC_WIDTH  group tag.
- d_ack_i  in  1  master ack.

Behaviour:
- Reset: synchronous, active-high. Drives s_ack_o=0, s_stall_o=0, d_cyc_o=0, d_stb_o=0, d_dat_o=0, d_sel_o=0, d_tgc_o=0. Clears the accumulator count, the output-valid flag and the latched cfg.
- Reset mid-group: discards all buffered data. A beat presented in the reset cycle is not accepted and is never acked.
- Accept: s_cyc_i & s_stb_i & !s_stall_o. s_ack_o is 1 in the cycle after each accept, exactly once per accepted beat.
- Master transfer: d_stb_o & d_ack_i. d_cyc_o equals d_stb_o. d_dat_o, d_sel_o and d_tgc_o are held stable while d_stb_o=1 and d_ack_i=0.
- Group start: the first beat of a group latches cfg_num_i (as N) and s_tgc_i. Changes to cfg_num_i mid-group are ignored.
- Lane placement, beat k (0-based):
  - LITTLE_ENDIAN=1: lane k = bits [k*DW +: DW].
  - LITTLE_ENDIAN=0: lane MAX_PACK-1-k.
  - d_sel_o bit i marks lane i as filled.
  - Unfilled lanes read 0.
- Complete group (count reaches N): on the edge that accepts the last beat, the group moves to the output register if that register is empty or is being acked in the same cycle. d_stb_o=1 on the next cycle. Otherwise the group stays in the accumulator, marked complete.
- Flush request: accumulator count>0 and either:
  - s_cyc_i=0, or
  - s_stb_i=1 with s_tgc_i ≠ latched tag.
  The partial group moves to the output under the same free-register rule. s_stall_o=1 while the flush is pending. A tag-change beat is accepted only after its flush and then starts a new group.
- s_stall_o=1 when:
  - the accumulator is complete and the output register is occupied and not being acked, or
  - a flush is pending.
  Otherwise s_stall_o=0.
- Throughput: with d_ack_i held 1, one beat per cycle with no stalls. Latency from the last beat's accept to d_stb_o is 1 cycle.
- Simultaneous d_ack_i and group move in the same cycle: the new word replaces the acked one with no bubble.
- Tag changes with an empty accumulator cause no flush and no stall.

Optional Feature:
- Macro WISH_PACK_FLEX_STATS_EN.
- Defined: adds two outputs:
  - stat_full_o [15:0]: count of complete groups transferred.
  - stat_part_o [15:0]: count of partial groups transferred.
  Both increment on the master transfer, saturate at 16'hFFFF, and are cleared by rst_i.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic packing, big-endian order (DW=8, MAX_PACK=4, LE=0, cfg=4, d_ack=1): beats 00,01,02,03 with tgc=1 on consecutive cycles -> single d_stb, d_dat=32'h00010203, d_sel=4'hF, d_tgc=1; s_ack high 4 cycles, each one cycle after its accept.
- Little-endian order (LE=1, same stimulus) -> d_dat=32'h03020100, d_sel=4'hF.
- Runtime ratio (cfg=2, beats 04..07) -> 32'h04050000 sel 4'hC, then 32'h06070000 sel 4'hC; changing cfg to 4 after beat 04 does not alter the first group.
- Partial flushes:
  - Beats 01,02 with tgc=0, then 03 with tgc=2 -> s_stall=1 for one cycle, then 32'h01020000 sel 4'hC tgc 0; 03 starts a new group.
  - Dropping s_cyc after one beat 09 -> 32'h09000000 sel 4'h8.
- Backpressure (d_ack=0, cfg=4): 8 beats accepted (one word in the output register, one complete group in the accumulator), 9th beat stalled; raising d_ack for 1 cycle -> second word presented next cycle and s_stall drops.
- Reset mid-group: assert rst_i after 2 beats -> all outputs 0 the next cycle; 4 fresh beats then produce a single clean word containing none of the old data; with STATS_EN, counters read 0 after reset and 1/1 after one full and one partial transfer.

Source files
------------

// File: rtl/wish_pack_flex.sv
// Wishbone-style width packer: narrow slave beats into one MAX_PACK-lane master word, runtime group size.
// Optional macro WISH_PACK_FLEX_STATS_EN adds transfer counters stat_full_o / stat_part_o.
module wish_pack_flex #(
   parameter int DATA_WIDTH    = 8,
   parameter int MAX_PACK      = 4,
   parameter int TGC_WIDTH     = 2,
   parameter bit LITTLE_ENDIAN = 1'b0,
   localparam int CW           = $clog2(MAX_PACK) + 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [CW-1:0]                  cfg_num_i,
   input  logic                           s_cyc_i,
   input  logic                           s_stb_i,
   input  logic [DATA_WIDTH-1:0]          s_dat_i,
   input  logic [TGC_WIDTH-1:0]           s_tgc_i,
   output logic                           s_stall_o,
   output logic                           s_ack_o,
   output logic                           d_cyc_o,
   output logic                           d_stb_o,
   output logic [DATA_WIDTH*MAX_PACK-1:0] d_dat_o,
   output logic [MAX_PACK-1:0]            d_sel_o,
   output logic [TGC_WIDTH-1:0]           d_tgc_o,
   input  logic                           d_ack_i
`ifdef WISH_PACK_FLEX_STATS_EN
   ,
   output logic [15:0]                    stat_full_o,
   output logic [15:0]                    stat_part_o
`endif
);

   localparam int            WW   = DATA_WIDTH * MAX_PACK;
   localparam logic [CW-1:0] MAXN = CW'(MAX_PACK);

   logic [WW-1:0]        acc_dat, out_dat, base_dat, mrg_dat;
   logic [MAX_PACK-1:0]  acc_sel, out_sel, base_sel, mrg_sel;
   logic [CW-1:0]        acc_cnt, acc_num, eff_num, beat_num, base_cnt, mrg_cnt, lane;
   logic [TGC_WIDTH-1:0] acc_tgc, out_tgc, beat_tgc;
   logic                 acc_full, out_vld, s_ack_r;
   logic                 out_free, flush_req, stall, accept;
   logic                 old_move, new_move, acc_open, mrg_done;

   always_comb begin
      eff_num   = (cfg_num_i == '0 || cfg_num_i > MAXN) ? MAXN : cfg_num_i;
      out_free  = !out_vld || d_ack_i;
      flush_req = (acc_cnt != '0) && (!s_cyc_i || (s_stb_i && (s_tgc_i != acc_tgc)));
      stall     = !rst_i && ((acc_full && out_vld && !d_ack_i) || flush_req);
      accept    = !rst_i && s_cyc_i && s_stb_i && !stall;
      old_move  = (acc_cnt != '0) && (acc_full || flush_req) && out_free;
      // A beat accepted while the accumulator drains starts a fresh group.
      acc_open  = (acc_cnt == '0) || old_move;
      beat_num  = acc_open ? eff_num : acc_num;
      beat_tgc  = acc_open ? s_tgc_i : acc_tgc;
      base_dat  = acc_open ? '0 : acc_dat;
      base_sel  = acc_open ? '0 : acc_sel;
      base_cnt  = acc_open ? '0 : acc_cnt;
      lane      = LITTLE_ENDIAN ? base_cnt : (MAXN - CW'(1) - base_cnt);
      mrg_dat   = base_dat;
      mrg_sel   = base_sel;
      for (int i = 0; i < MAX_PACK; i++) begin
         if (lane == CW'(i)) begin
            mrg_dat[i*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
            mrg_sel[i]                          = 1'b1;
         end
      end
      mrg_cnt   = base_cnt + CW'(1);
      mrg_done  = (mrg_cnt == beat_num);
      new_move  = accept && mrg_done && out_free && !old_move;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_ack_r  <= 1'b0;
         out_vld  <= 1'b0;
         out_dat  <= '0;
         out_sel  <= '0;
         out_tgc  <= '0;
         acc_dat  <= '0;
         acc_sel  <= '0;
         acc_cnt  <= '0;
         acc_num  <= '0;
         acc_tgc  <= '0;
         acc_full <= 1'b0;
      end else begin
         s_ack_r <= accept;
         if (old_move) begin
            out_vld <= 1'b1;
            out_dat <= acc_dat;
            out_sel <= acc_sel;
            out_tgc <= acc_tgc;
         end else if (new_move) begin
            out_vld <= 1'b1;
            out_dat <= mrg_dat;
            out_sel <= mrg_sel;
            out_tgc <= beat_tgc;
         end else if (d_ack_i) begin
            out_vld <= 1'b0;
         end
         if (accept && !new_move) begin
            acc_dat  <= mrg_dat;
            acc_sel  <= mrg_sel;
            acc_cnt  <= mrg_cnt;
            acc_num  <= beat_num;
            acc_tgc  <= beat_tgc;
            acc_full <= mrg_done;
         end else if (old_move || new_move) begin
            acc_dat  <= '0;
            acc_sel  <= '0;
            acc_cnt  <= '0;
            acc_full <= 1'b0;
         end
      end
   end

`ifdef WISH_PACK_FLEX_STATS_EN
   logic        out_cmp;
   logic [15:0] cnt_full, cnt_part;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_cmp  <= 1'b0;
         cnt_full <= '0;
         cnt_part <= '0;
      end else begin
         if (old_move)
            out_cmp <= acc_full;
         else if (new_move)
            out_cmp <= 1'b1;
         if (out_vld && d_ack_i) begin
            if (out_cmp && cnt_full != 16'hFFFF)
               cnt_full <= cnt_full + 16'd1;
            if (!out_cmp && cnt_part != 16'hFFFF)
               cnt_part <= cnt_part + 16'd1;
         end
      end
   end

   assign stat_full_o = cnt_full;
   assign stat_part_o = cnt_part;
`endif

   assign s_stall_o = stall;
   assign s_ack_o   = s_ack_r;
   assign d_cyc_o   = out_vld;
   assign d_stb_o   = out_vld;
   assign d_dat_o   = out_dat;
   assign d_sel_o   = out_sel;
   assign d_tgc_o   = out_tgc;

endmodule

// File: tb/tb_wish_pack_flex.sv
// Directed bench for wish_pack_flex: big- and little-endian instances share one stimulus stream.
module tb_wish_pack_flex;
   localparam int DW = 8;
   localparam int MP = 4;
   localparam int TW = 2;
   localparam int CW = 3;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [CW-1:0] cfg_num_i = 3'd4;
   logic [CW-1:0] cfg_nxt = 3'd4;
   logic          s_cyc_i = 1'b0, s_stb_i = 1'b0, d_ack_i = 1'b1;
   logic [DW-1:0] s_dat_i = '0;
   logic [TW-1:0] s_tgc_i = '0;

   logic          be_stall, be_ack, be_cyc, be_stb, le_stall, le_ack, le_cyc, le_stb;
   logic [31:0]   be_dat, le_dat;
   logic [3:0]    be_sel, le_sel;
   logic [1:0]    be_tgc, le_tgc;
`ifdef WISH_PACK_FLEX_STATS_EN
   logic [15:0]   be_sf, be_sp, le_sf, le_sp;
`endif

   int            checks = 0;
   int            failures = 0;
   logic [37:0]   be_q[$];
   logic [37:0]   le_q[$];

   always #5 clk_i = ~clk_i;

   wish_pack_flex #(.DATA_WIDTH(DW), .MAX_PACK(MP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1'b0)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cfg_num_i(cfg_num_i),
      .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
      .s_stall_o(be_stall), .s_ack_o(be_ack),
      .d_cyc_o(be_cyc), .d_stb_o(be_stb), .d_dat_o(be_dat), .d_sel_o(be_sel), .d_tgc_o(be_tgc),
      .d_ack_i(d_ack_i)
`ifdef WISH_PACK_FLEX_STATS_EN
      , .stat_full_o(be_sf), .stat_part_o(be_sp)
`endif
   );

   wish_pack_flex #(.DATA_WIDTH(DW), .MAX_PACK(MP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1'b1)) dut_le (
      .clk_i(clk_i), .rst_i(rst_i), .cfg_num_i(cfg_num_i),
      .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
      .s_stall_o(le_stall), .s_ack_o(le_ack),
      .d_cyc_o(le_cyc), .d_stb_o(le_stb), .d_dat_o(le_dat), .d_sel_o(le_sel), .d_tgc_o(le_tgc),
      .d_ack_i(d_ack_i)
`ifdef WISH_PACK_FLEX_STATS_EN
      , .stat_full_o(le_sf), .stat_part_o(le_sp)
`endif
   );

   // Log every master transfer as {tgc, sel, dat}.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (be_stb && d_ack_i) be_q.push_back({be_tgc, be_sel, be_dat});
         if (le_stb && d_ack_i) le_q.push_back({le_tgc, le_sel, le_dat});
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic c, input logic s, input logic [7:0] d,
                        input logic [1:0] t, input logic a);
      @(posedge clk_i);
      #1;
      s_cyc_i   = c;
      s_stb_i   = s;
      s_dat_i   = d;
      s_tgc_i   = t;
      d_ack_i   = a;
      cfg_num_i = cfg_nxt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
   endtask

   task automatic pop_check(input string tag, input logic [37:0] exp_be, input logic [37:0] exp_le);
      logic [37:0] w;
      if (be_q.size() != 0) w = be_q.pop_front(); else w = '1;
      check(tag, 64'(w), 64'(exp_be));
      if (le_q.size() != 0) w = le_q.pop_front(); else w = '1;
      check({tag, "_le"}, 64'(w), 64'(exp_le));
   endtask

   task automatic chk_empty(input string tag);
      check(tag, 64'(be_q.size() + le_q.size()), 64'h0);
   endtask

   task automatic check_zero(input string tag);
      check(tag, 64'({be_stall, be_ack, be_cyc, be_stb, be_dat, be_sel, be_tgc}), 64'h0);
      check({tag, "_le"}, 64'({le_stall, le_ack, le_cyc, le_stb, le_dat, le_sel, le_tgc}), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_zero("reset_state");
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Basic packing, four beats, tag 1
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 8'(i), 2'd1, 1'b1);
         @(negedge clk_i);
         check("t1_ack", 64'(be_ack), 64'(i != 0));
         check("t1_stall", 64'(be_stall), 64'h0);
      end
      idle(1);
      @(negedge clk_i);
      check("t1_ack_last", 64'(be_ack), 64'h1);
      check("t1_stb", 64'(be_stb), 64'h1);
      check("t1_cyc", 64'(be_cyc), 64'h1);
      check("t1_dat", 64'(be_dat), 64'h00010203);
      check("t1_dat_le", 64'(le_dat), 64'h03020100);
      idle(1);
      @(negedge clk_i);
      check("t1_ack_end", 64'(be_ack), 64'h0);
      check("t1_stb_end", 64'(be_stb), 64'h0);
      pop_check("t1_word", {2'd1, 4'hF, 32'h00010203}, {2'd1, 4'hF, 32'h03020100});
      chk_empty("t1_extra");

      // Runtime ratio 2, cfg bumped to 4 mid-group
      cfg_nxt = 3'd2; drive(1'b1, 1'b1, 8'h04, 2'd0, 1'b1);
      cfg_nxt = 3'd4; drive(1'b1, 1'b1, 8'h05, 2'd0, 1'b1);
      cfg_nxt = 3'd2; drive(1'b1, 1'b1, 8'h06, 2'd0, 1'b1);
      drive(1'b1, 1'b1, 8'h07, 2'd0, 1'b1);
      idle(3);
      cfg_nxt = 3'd4;
      pop_check("t2_word0", {2'd0, 4'hC, 32'h04050000}, {2'd0, 4'h3, 32'h00000504});
      pop_check("t2_word1", {2'd0, 4'hC, 32'h06070000}, {2'd0, 4'h3, 32'h00000706});
      chk_empty("t2_extra");

      // Tag-change flush, cyc-drop flush, tag change on empty accumulator
      drive(1'b1, 1'b1, 8'h01, 2'd0, 1'b1);
      drive(1'b1, 1'b1, 8'h02, 2'd0, 1'b1);
      drive(1'b1, 1'b1, 8'h03, 2'd2, 1'b1);
      @(negedge clk_i);
      check("t3_stall_flush", 64'(be_stall), 64'h1);
      drive(1'b1, 1'b1, 8'h03, 2'd2, 1'b1);
      @(negedge clk_i);
      check("t3_stall_drop", 64'(be_stall), 64'h0);
      check("t3_stb", 64'(be_stb), 64'h1);
      check("t3_word_live", 64'({be_tgc, be_sel, be_dat}), 64'({2'd0, 4'hC, 32'h01020000}));
      idle(1);
      drive(1'b1, 1'b1, 8'h09, 2'd1, 1'b1);
      @(negedge clk_i);
      check("t3_tag_empty", 64'(be_stall), 64'h0);
      idle(3);
      pop_check("t3_word0", {2'd0, 4'hC, 32'h01020000}, {2'd0, 4'h3, 32'h00000201});
      pop_check("t3_word1", {2'd2, 4'h8, 32'h03000000}, {2'd2, 4'h1, 32'h00000003});
      pop_check("t3_word2", {2'd1, 4'h8, 32'h09000000}, {2'd1, 4'h1, 32'h00000009});
      chk_empty("t3_extra");

      // Backpressure: eight beats absorbed, ninth stalled
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 8'(8'h10 + i), 2'd3, 1'b0);
         @(negedge clk_i);
         check("t4_no_stall", 64'(be_stall), 64'h0);
      end
      drive(1'b1, 1'b1, 8'h18, 2'd3, 1'b0);
      @(negedge clk_i);
      check("t4_stall9", 64'(be_stall), 64'h1);
      check("t4_hold0", 64'(be_dat), 64'h10111213);
      drive(1'b1, 1'b1, 8'h18, 2'd3, 1'b1);
      @(negedge clk_i);
      check("t4_stall_ack", 64'(be_stall), 64'h0);
      drive(1'b1, 1'b0, 8'h00, 2'd3, 1'b0);
      @(negedge clk_i);
      check("t4_stb1", 64'(be_stb), 64'h1);
      check("t4_word1", 64'({be_sel, be_dat}), 64'({4'hF, 32'h14151617}));
      check("t4_stall_after", 64'(be_stall), 64'h0);
      drive(1'b1, 1'b0, 8'h00, 2'd3, 1'b0);
      @(negedge clk_i);
      check("t4_hold1", 64'(be_dat), 64'h14151617);
      idle(4);
      pop_check("t4_w0", {2'd3, 4'hF, 32'h10111213}, {2'd3, 4'hF, 32'h13121110});
      pop_check("t4_w1", {2'd3, 4'hF, 32'h14151617}, {2'd3, 4'hF, 32'h17161514});
      pop_check("t4_w2", {2'd3, 4'h8, 32'h18000000}, {2'd3, 4'h1, 32'h00000018});
      chk_empty("t4_extra");

      // Reset mid-group with a beat presented in the reset cycle
      drive(1'b1, 1'b1, 8'h20, 2'd0, 1'b1);
      drive(1'b1, 1'b1, 8'h21, 2'd0, 1'b1);
      drive(1'b1, 1'b1, 8'h22, 2'd0, 1'b1);
      rst_i = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_zero("t5_after_reset");
`ifdef WISH_PACK_FLEX_STATS_EN
      check("t5_stats_clr", 64'({be_sf, be_sp}), 64'h0);
`endif
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'(8'h30 + i), 2'd1, 1'b1);
      idle(3);
      pop_check("t5_word", {2'd1, 4'hF, 32'h30313233}, {2'd1, 4'hF, 32'h33323130});
`ifdef WISH_PACK_FLEX_STATS_EN
      drive(1'b1, 1'b1, 8'h40, 2'd1, 1'b1);
      idle(3);
      @(negedge clk_i);
      check("t5_stats_be", 64'({be_sf, be_sp}), 64'h0001_0001);
      check("t5_stats_le", 64'({le_sf, le_sp}), 64'h0001_0001);
      pop_check("t5_part", {2'd1, 4'h8, 32'h40000000}, {2'd1, 4'h1, 32'h00000040});
`endif
      chk_empty("t5_extra");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
